// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmitter. Serialises a WIDTH-bit word LSB first,
// framed by one start bit and STOP_BITS stop bits. Each bit lasts DIV
// ref_clk cycles. A level-sensitive send/done handshake lets a source chain
// frames back to back with no idle gap.
//
// Optional build macro: UART_TX_PARITY_EN
//   Defined   : a parity bit (PARITY 1 = even, 2 = odd) is inserted between
//               the last data bit and the first stop bit.
//   Undefined : no parity logic; PARITY is ignored.
//
// Ports:
//   ref_clk  in   system clock, all logic on its rising edge
//   reset    in   synchronous active-high reset
//   send     in   level request to start a frame
//   in       in   WIDTH-bit data word, sampled only when a frame starts
//   done     out  high for the whole final stop-bit period
//   busy     out  high from frame start through the last stop-bit cycle
//   out      out  registered serial line
// ---------------------------------------------------------------------------
module uart_tx_frame #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIV       = 1,
   parameter int unsigned STOP_BITS = 1,
   parameter int unsigned INVERT    = 1,
   parameter int unsigned PARITY    = 0
) (
   input  logic             ref_clk,
   input  logic             reset,
   input  logic             send,
   input  logic [WIDTH-1:0] in,
   output logic             done,
   output logic             busy,
   output logic             out
);

   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

   // Line levels; data bits are XOR-ed with ~INVERT, which equals the idle level.
   localparam logic IDLE_LVL  = (INVERT == 0) ? 1'b1 : 1'b0;
   localparam logic START_LVL = ~IDLE_LVL;
   localparam logic STOP_LVL  = IDLE_LVL;
   localparam logic DATA_XOR  = IDLE_LVL;

   // Elaboration-time parameter legality checks.
   if (WIDTH < 5 || WIDTH > 16) begin : g_bad_width
      $error("uart_tx_frame: WIDTH must be in 5..16");
   end
   if (DIV < 1) begin : g_bad_div
      $error("uart_tx_frame: DIV must be >= 1");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (INVERT > 1) begin : g_bad_invert
      $error("uart_tx_frame: INVERT must be 0 or 1");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q,   div_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             out_q,   out_d;
   logic             done_q,  done_d;
   logic             busy_q,  busy_d;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_ON = (PARITY == 1) || (PARITY == 2);
   logic             parity_q, parity_d;
`endif

   logic             bit_end;
   logic             load;
   logic             stop_entry;

   // State register.
   always_ff @(posedge ref_clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         cnt_q    <= '0;
         shift_q  <= '0;
         out_q    <= IDLE_LVL;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         out_q    <= out_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      out_d      = out_q;
      done_d     = done_q;
      busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      load       = 1'b0;
      stop_entry = 1'b0;
      bit_end    = (div_q == DIV_LAST);

      // Bit-period divider free-runs 0..DIV-1 while a frame is active.
      if (state_q != S_IDLE) begin
         div_d = bit_end ? '0 : div_q + DIV_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            out_d  = IDLE_LVL;
            done_d = 1'b0;
            busy_d = 1'b0;
            div_d  = '0;
            cnt_d  = '0;
            load   = send;
         end

         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               cnt_d   = '0;
               out_d   = shift_q[0] ^ DATA_XOR;
               shift_d = shift_q >> 1;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               if (cnt_q == WORD_LAST) begin
`ifdef UART_TX_PARITY_EN
                  if (PAR_ON) begin
                     state_d = S_PARITY;
                     out_d   = parity_q ^ DATA_XOR;
                  end else begin
                     stop_entry = 1'b1;
                  end
`else
                  stop_entry = 1'b1;
`endif
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  out_d   = shift_q[0] ^ DATA_XOR;
                  shift_d = shift_q >> 1;
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               stop_entry = 1'b1;
            end
         end
`endif

         S_STOP: begin
            if (bit_end) begin
               if (cnt_q == STOP_LAST) begin
                  // End of frame: chain straight into the next start bit if requested.
                  if (send) begin
                     load = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     out_d   = IDLE_LVL;
                     busy_d  = 1'b0;
                     done_d  = 1'b0;
                     cnt_d   = '0;
                  end
               end else begin
                  // Entering the last of two stop bits.
                  cnt_d  = cnt_q + CNT_W'(1);
                  done_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (stop_entry) begin
         state_d = S_STOP;
         cnt_d   = '0;
         out_d   = STOP_LVL;
         done_d  = (STOP_BITS == 1);
      end

      // Frame start: latch the word and drive the start bit on this edge.
      if (load) begin
         state_d  = S_START;
         shift_d  = in;
         out_d    = START_LVL;
         busy_d   = 1'b1;
         done_d   = 1'b0;
         div_d    = '0;
         cnt_d    = '0;
`ifdef UART_TX_PARITY_EN
         parity_d = (PARITY == 2) ? ~(^in) : (^in);
`endif
      end
   end

   assign out  = out_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
// Two DUT instances with different configurations. Stimulus pushes each
// word it offers into a per-instance queue; a monitor per instance detects
// frames on the serial line, pops the expected word and compares every
// cycle of the frame against a waveform computed from the framing rules.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   // Instance configurations: u0 = DIV 1, 1 stop, INVERT 1, even parity;
   // u1 = DIV 3, 2 stop, INVERT 0, odd parity.
   int div_c  [2] = '{1, 3};
   int stop_c [2] = '{1, 2};
   bit inv_c  [2] = '{1'b1, 1'b0};
   int par_c  [2] = '{1, 2};

   logic       ref_clk = 1'b0;
   logic       rst0, rst1, send0, send1;
   logic [7:0] in0, in1;
   logic       out0, out1, busy0, busy1, done0, done1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   always #5 ref_clk = ~ref_clk;

   uart_tx_frame #(.WIDTH(8), .DIV(1), .STOP_BITS(1), .INVERT(1), .PARITY(1)) u0 (
      .ref_clk(ref_clk), .reset(rst0), .send(send0), .in(in0),
      .done(done0), .busy(busy0), .out(out0));

   uart_tx_frame #(.WIDTH(8), .DIV(3), .STOP_BITS(2), .INVERT(0), .PARITY(2)) u1 (
      .ref_clk(ref_clk), .reset(rst1), .send(send1), .in(in1),
      .done(done1), .busy(busy1), .out(out1));

   task automatic check(input bit ok, input string name, input int act, input int req);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   function automatic int par_bits(int id);
      return (PAR_EN && par_c[id] != 0) ? 1 : 0;
   endfunction

   function automatic int frame_len(int id);
      return (1 + 8 + par_bits(id) + stop_c[id]) * div_c[id];
   endfunction

   // Required line level at cycle c of a frame carrying word w.
   function automatic logic exp_level(int id, logic [7:0] w, int c);
      int   b;
      logic iv;
      logic p;
      iv = inv_c[id];
      b  = c / div_c[id];
      if (b == 0) return iv;
      if (b <= 8) return w[b-1] ^ ~iv;
      if (par_bits(id) == 1 && b == 9) begin
         p = ^w;
         if (par_c[id] == 2) p = ~p;
         return p ^ ~iv;
      end
      return ~iv;
   endfunction

   function automatic logic get_busy(int id);
      return (id == 0) ? busy0 : busy1;
   endfunction

   function automatic logic get_done(int id);
      return (id == 0) ? done0 : done1;
   endfunction

   task automatic push(input int id, input logic [7:0] w);
      if (id == 0) q0.push_back(w);
      else         q1.push_back(w);
   endtask

   task automatic set_in(input int id, input logic s, input logic [7:0] w);
      if (id == 0) begin send0 = s; in0 = w; end
      else         begin send1 = s; in1 = w; end
   endtask

   task automatic set_send(input int id, input logic s);
      if (id == 0) send0 = s;
      else         send1 = s;
   endtask

   task automatic tick();
      @(posedge ref_clk);
      #1;
   endtask

   task automatic wait_idle(input int id);
      int n = 0;
      while (get_busy(id) && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) check(1'b0, $sformatf("timeout_idle_u%0d", id), n, 500);
   endtask

   task automatic wait_done_rise(input int id);
      int n = 0;
      while (get_done(id) && n < 500) begin
         tick();
         n++;
      end
      while (!get_done(id) && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) check(1'b0, $sformatf("timeout_done_u%0d", id), n, 500);
   endtask

   // One-edge send; the word is then scrambled to show mid-frame changes are ignored.
   task automatic single(input int id, input logic [7:0] w);
      wait_idle(id);
      set_in(id, 1'b1, w);
      push(id, w);
      tick();
      set_in(id, 1'b0, 8'($urandom));
   endtask

   // send held high; the next word is presented when done rises.
   task automatic b2b(input int id, input logic [7:0] ws[$]);
      wait_idle(id);
      set_in(id, 1'b1, ws[0]);
      push(id, ws[0]);
      for (int i = 1; i < ws.size(); i++) begin
         wait_done_rise(id);
         set_in(id, 1'b1, ws[i]);
         push(id, ws[i]);
      end
      wait_done_rise(id);
      set_send(id, 1'b0);
   endtask

   task automatic monitor(input int id);
      bit         inf = 1'b0;
      int         c = 0;
      int         errs = 0;
      int         first_bad = -1;
      int         len;
      logic [7:0] w = '0;
      logic       o, b, d, r, idle, eo, ed;
      len  = frame_len(id);
      idle = ~inv_c[id];
      forever begin
         @(negedge ref_clk);
         o = (id == 0) ? out0  : out1;
         b = (id == 0) ? busy0 : busy1;
         d = (id == 0) ? done0 : done1;
         r = (id == 0) ? rst0  : rst1;
         if (!inf && (b || o !== idle)) begin
            inf = 1'b1; c = 0; errs = 0; first_bad = -1;
            if (id == 0 && q0.size() != 0)      w = q0.pop_front();
            else if (id == 1 && q1.size() != 0) w = q1.pop_front();
            else begin
               w = '0;
               check(1'b0, $sformatf("unexpected_frame_u%0d", id), 1, 0);
            end
         end
         if (inf) begin
            eo = exp_level(id, w, c);
            ed = (c >= len - div_c[id]);
            if (o !== eo || d !== ed || b !== 1'b1) begin
               errs++;
               if (first_bad < 0) first_bad = c;
            end
            c++;
            if (r) begin
               check(errs == 0, $sformatf("partial_frame_u%0d_%02h", id, w), first_bad, -1);
               inf = 1'b0;
            end else if (c == len) begin
               check(errs == 0, $sformatf("frame_u%0d_%02h_first_bad_cycle", id, w), first_bad, -1);
               inf = 1'b0;
            end
         end else begin
            check(o === idle && b === 1'b0 && d === 1'b0, $sformatf("idle_u%0d_obd", id),
                  int'({o, b, d}), int'({idle, 2'b00}));
         end
      end
   endtask

   initial begin
      logic [7:0] wq[$];
      int         id;
      int         n;

      rst0 = 1'b1; rst1 = 1'b1;
      send0 = 1'b0; send1 = 1'b0;
      in0 = '0; in1 = '0;
      repeat (3) @(posedge ref_clk);
      #1;
      rst0 = 1'b0; rst1 = 1'b0;

      fork
         monitor(0);
         monitor(1);
      join_none

      // Idle after reset.
      repeat (3) tick();

      // Single frame, then back-to-back chain.
      single(0, 8'hA9);
      wq.delete();
      wq.push_back(8'hA1); wq.push_back(8'hB2); wq.push_back(8'hC3);
      b2b(0, wq);

      // Divider and two stop bits.
      single(1, 8'hCA);

      // Parity word on both parity modes.
      single(0, 8'h07);
      single(1, 8'h07);

      // Reset during data bit 4, then a clean frame.
      wait_idle(0);
      set_in(0, 1'b1, 8'h5E);
      push(0, 8'h5E);
      tick();
      set_send(0, 1'b0);
      repeat (5) tick();
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      check(out0 === 1'b0 && busy0 === 1'b0 && done0 === 1'b0, "reset_mid_frame_obd",
            int'({out0, busy0, done0}), 0);
      single(0, 8'hD4);

      // Reset during a u1 frame with send still asserted: reset wins.
      wait_idle(1);
      set_in(1, 1'b1, 8'h3C);
      push(1, 8'h3C);
      repeat (7) tick();
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      set_send(1, 1'b0);
      check(out1 === 1'b1 && busy1 === 1'b0 && done1 === 1'b0, "reset_u1_obd",
            int'({out1, busy1, done1}), 4);

      // Randomised single and chained frames on both instances.
      repeat (10) begin
         id = int'($urandom_range(0, 1));
         n  = int'($urandom_range(1, 3));
         if (n == 1) begin
            single(id, 8'($urandom));
         end else begin
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
            b2b(id, wq);
         end
      end

      wait_idle(0);
      wait_idle(1);
      repeat (3) tick();
      check(q0.size() == 0, "pending_u0", q0.size(), 0);
      check(q1.size() == 0, "pending_u1", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised successor of the single-rate UART transmitter.
- Serialises a WIDTH-bit word, LSB first, framed by a start bit and 1 or 2 stop bits.
- Bit rate comes from an internal divider on the single system clock, so no separate bit clock is needed.
- Sits between a byte source (FIFO or register) and the serial output pin. Level-sensitive send/done handshake supports back-to-back frames with no idle gap.

Parameters:
- WIDTH, 8, data bits per frame; legal range 5..16.
- DIV, 1, ref_clk cycles per bit period; must be >= 1; DIV=1 gives one bit per clock.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- INVERT, 1, line polarity. 1: idle=0, start=1, stop=0, data bit 1 driven as 1 (existing team polarity). 0: idle=1, start=0, stop=1 (standard UART).
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd. Takes effect only with UART_TX_PARITY_EN.

Ports:
- ref_clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- send  input  1  level request: transmit `in` when the block is able to start a frame.
- in  input  WIDTH  data word, sampled only on the cycle a frame starts.
- done  output  1  high for the whole final stop-bit period.
- busy  output  1  high from frame start through the last stop-bit cycle.
- out  output  1  serial line, registered.

Behaviour:
- Interface: one clock (ref_clk); reset is synchronous and active-high.
- Reset values: out = idle level (0 when INVERT=1, 1 when INVERT=0), done=0, busy=0, state=IDLE, divider=0, bit counter=0.
- States and transitions:
  - IDLE: out at idle level. A rising edge with send=1 latches `in` into the shift register, sets out to start level, busy=1, and enters START.
  - START: out at start level.
  - DATA: WIDTH bit periods. Bit k (k=0 first) is driven as in[k], XOR-ed with ~INVERT so a data 1 is a mark in the active polarity.
  - PARITY: present only when compiled in and PARITY != 0.
  - STOP: STOP_BITS periods at stop level.
- Bit timing:
  - Each state/bit holds out for exactly DIV cycles, timed by a divider counting 0..DIV-1.
  - The bit advances on the cycle the divider equals DIV-1.
- Frame length in cycles: (1 + WIDTH + P + STOP_BITS) * DIV, with P=1 if parity is active, else 0.
- Latency: start bit appears on out at the first rising edge where send=1 and state=IDLE. No extra pipeline stage.
- done:
  - Asserted on the same edge out enters the last stop bit.
  - Held for DIV cycles; deasserted when that period ends.
  - With STOP_BITS=2, done covers only the second stop bit.
- Back-to-back: on the final cycle of the last stop bit, if send=1, `in` is re-sampled and START entered directly. Zero idle cycles; busy stays 1. Otherwise go to IDLE with busy=0.
- The source may change `in` any time done=1. `in` is not sampled mid-frame, and changes during a frame have no effect.
- send dropping mid-frame does not abort; the frame completes.
- Reset mid-frame: the next edge returns out to idle level, clears done/busy, and discards the shifted word.
- Reset and send high together: reset wins.

Optional Feature:
- UART_TX_PARITY_EN.
- Defined: a parity bit is inserted between data bit WIDTH-1 and the first stop bit when PARITY is 1 or 2.
  - The bit is the even/odd parity of the latched word, subject to the same INVERT mapping as data.
  - PARITY=0 still produces no parity bit.
- Undefined: no parity logic is synthesised, PARITY is ignored, and frame length uses P=0.

Test Plan:
- Reset/idle: hold reset 3 cycles, then 3 idle cycles with send=0 and INVERT=1 -> out=0, done=0, busy=0 every cycle.
- Single frame: WIDTH=8, DIV=1, in=8'hA9, send=1 for one edge.
  - Required out sequence: 1 then 1,0,0,1,0,1,0,1 then 0.
  - done=1 only on the stop cycle; capture register equals 8'hA9.
- Back-to-back handshake: send held 1; change in to 8'hA1, 8'hB2, 8'hC3 at each posedge done.
  - Each frame decodes correctly with no idle cycle between frames.
  - 10-cycle period.
- Divider and stop bits: DIV=3, STOP_BITS=2, in=8'hCA.
  - Each bit lasts 3 cycles; frame is 33 cycles.
  - done high for the final 3 cycles only.
- Parity: compiled with UART_TX_PARITY_EN, PARITY=1, in=8'h07 -> parity bit 1 inserted before stop; with PARITY=2 -> parity bit 0.
  - Built without the macro: identical stimulus gives a 10-cycle frame.
- Reset mid-frame: assert reset during data bit 4 -> out returns to idle and done=busy=0 on the next edge.
  - A subsequent send of 8'hD4 transmits cleanly.
